// File: rtl/nervous_alarm_pkg.sv
// Shared types for the nervous alarm controller: FSM state encoding and severity codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package nervous_alarm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_QUALIFY = 2'd1,
      ST_ALARM   = 2'd2,
      ST_HOLDOFF = 2'd3
   } state_t;

   localparam logic [1:0] NORMAL   = 2'd0;
   localparam logic [1:0] MILD     = 2'd1;
   localparam logic [1:0] SEVERE   = 2'd2;
   localparam logic [1:0] CRITICAL = 2'd3;

endpackage

// File: rtl/abnormality_persistence_filter.sv
// Tracks runs of identical non-zero severity codes and pulses when a run reaches PERSIST_CYCLES.
// Latency: qualified is combinational on the edge that samples the PERSIST_CYCLES-th matching code.
// Backpressure: none; enable=0 clears the run so a new qualification always needs a full run.
// Ports: clock, reset (sync, active-high), enable (FSM is idle/qualifying), sample (severity code),
//        qualified (pulse, this edge completes a run), candidate (code of the run after this edge).
module abnormality_persistence_filter
   import nervous_alarm_pkg::*;
#(
   parameter int PERSIST_CYCLES = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       enable,
   input  logic [1:0] sample,
   output logic       qualified,
   output logic [1:0] candidate
);

   localparam logic [7:0] PERSIST_W = 8'(PERSIST_CYCLES);

   logic [1:0] cand_q, cand_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] run_len;

   always_comb begin
      cand_d    = cand_q;
      cnt_d     = cnt_q;
      qualified = 1'b0;
      run_len   = 8'd0;
      if (!enable || sample == NORMAL) begin
         cand_d = NORMAL;
         cnt_d  = 8'd0;
      end else begin
         // A live run continues only on an exact code match; any other non-zero code starts over.
         if (cnt_q != 8'd0 && sample == cand_q) begin
            run_len = cnt_q + 8'd1;
         end else begin
            run_len = 8'd1;
         end
         cand_d = sample;
         if (run_len == PERSIST_W) begin
            qualified = 1'b1;
            cnt_d     = 8'd0;
         end else begin
            cnt_d = run_len;
         end
      end
      candidate = cand_d;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cand_q <= NORMAL;
         cnt_q  <= 8'd0;
      end else begin
         cand_q <= cand_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: rtl/nervous_alarm_controller.sv
// Raises a latched alarm after PERSIST_CYCLES identical non-zero severity samples; ack starts a holdoff.
// Latency: alarm/alarmLevel/eventCount update on the edge sampling the qualifying code (registered outputs).
// Backpressure: none; inputs are ignored while in HOLDOFF, ack is ignored outside ALARM.
// Ports: clock, reset (sync, active-high), nervousAbnormality (severity code), ack (operator level),
//        alarm, alarmLevel, eventCount (saturating count of qualified alarms).
// Macro NERVOUS_ALARM_ESCALATION_EN: when defined, a higher code during ALARM raises alarmLevel.
module nervous_alarm_controller
   import nervous_alarm_pkg::*;
#(
   parameter int PERSIST_CYCLES = 4,
   parameter int HOLDOFF_CYCLES = 8,
   parameter int CNT_WIDTH      = 8
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [1:0]           nervousAbnormality,
   input  logic                 ack,
   output logic                 alarm,
   output logic [1:0]           alarmLevel,
   output logic [CNT_WIDTH-1:0] eventCount
);

   localparam logic [7:0]           HOLD_LAST = 8'(HOLDOFF_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] EVENT_MAX = {CNT_WIDTH{1'b1}};

   state_t               state_q, state_d;
   logic                 alarm_q, alarm_d;
   logic [1:0]           level_q, level_d;
   logic [CNT_WIDTH-1:0] event_q, event_d;
   logic [7:0]           hold_q, hold_d;

   logic       filt_en;
   logic       qualified;
   logic [1:0] candidate;

   assign filt_en = (state_q == ST_IDLE) || (state_q == ST_QUALIFY);

   abnormality_persistence_filter #(
      .PERSIST_CYCLES(PERSIST_CYCLES)
   ) u_filter (
      .clock     (clock),
      .reset     (reset),
      .enable    (filt_en),
      .sample    (nervousAbnormality),
      .qualified (qualified),
      .candidate (candidate)
   );

   always_comb begin
      state_d = state_q;
      alarm_d = alarm_q;
      level_d = level_q;
      event_d = event_q;
      hold_d  = hold_q;
      case (state_q)
         ST_IDLE, ST_QUALIFY: begin
            if (qualified) begin
               state_d = ST_ALARM;
               alarm_d = 1'b1;
               level_d = candidate;
               if (event_q != EVENT_MAX) begin
                  event_d = event_q + 1'b1;
               end
            end else if (nervousAbnormality != NORMAL) begin
               state_d = ST_QUALIFY;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ALARM: begin
`ifdef NERVOUS_ALARM_ESCALATION_EN
            // Escalation wins over a coincident ack so a worsening event is never silenced.
            if (nervousAbnormality > level_q) begin
               level_d = nervousAbnormality;
            end else if (ack) begin
               state_d = ST_HOLDOFF;
               alarm_d = 1'b0;
               hold_d  = 8'd0;
            end
`else
            if (ack) begin
               state_d = ST_HOLDOFF;
               alarm_d = 1'b0;
               hold_d  = 8'd0;
            end
`endif
         end
         ST_HOLDOFF: begin
            // hold_q counts HOLDOFF edges already spent; the last one returns to IDLE.
            if (hold_q == HOLD_LAST) begin
               state_d = ST_IDLE;
               hold_d  = 8'd0;
               level_d = NORMAL;
            end else begin
               hold_d = hold_q + 8'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         alarm_q <= 1'b0;
         level_q <= NORMAL;
         event_q <= '0;
         hold_q  <= 8'd0;
      end else begin
         state_q <= state_d;
         alarm_q <= alarm_d;
         level_q <= level_d;
         event_q <= event_d;
         hold_q  <= hold_d;
      end
   end

   assign alarm      = alarm_q;
   assign alarmLevel = level_q;
   assign eventCount = event_q;

endmodule

// File: doc/nervous_alarm_controller.md
NERVOUS_ALARM_CONTROLLER -- requirements
Module: nervous_alarm_controller

Interface
REQ-001 SHALL have parameter PERSIST_CYCLES, default 4: consecutive identical non-zero samples required to raise an alarm (legal range 1..255).
REQ-002 SHALL have parameter HOLDOFF_CYCLES, default 8: cycles after acknowledge during which input is ignored (legal range 1..255).
REQ-003 SHALL have parameter CNT_WIDTH, default 8: width of eventCount.
REQ-004 SHALL have port clock, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port nervousAbnormality, input, 2: severity code from the shock detector (0 normal, 1 mild, 2 severe, 3 critical), sampled every rising edge.
REQ-007 SHALL have port ack, input, 1: operator acknowledge, level-sampled each edge.
REQ-008 SHALL have port alarm, output, 1: registered alarm flag.
REQ-009 SHALL have port alarmLevel, output, 2: registered latched severity of the active alarm.
REQ-010 SHALL have port eventCount, output, CNT_WIDTH: registered count of qualified alarms since reset.

Function
REQ-011 SHALL implement FSM with states IDLE, QUALIFY, ALARM, HOLDOFF.
REQ-012 IDLE: non-zero sample -> QUALIFY, candidate code := sample, persistence count := 1; zero sample -> stay; ack ignored.
REQ-013 QUALIFY: sample == candidate -> count+1; different non-zero sample -> candidate := sample, count := 1; zero sample -> IDLE, count := 0.
REQ-014 The edge sampling the PERSIST_CYCLES-th consecutive matching code SHALL enter ALARM and set alarm=1, alarmLevel=candidate, eventCount+1 on that same edge; with PERSIST_CYCLES=1, this edge is the one leaving IDLE.
REQ-015 eventCount SHALL saturate at 2^CNT_WIDTH-1 and never wrap.
REQ-016 ALARM: alarm held at 1 regardless of input until ack=1 is sampled; then next state HOLDOFF, alarm := 0.
REQ-017 HOLDOFF: alarm=0, alarmLevel retained, input and ack ignored for exactly HOLDOFF_CYCLES edges, then IDLE with alarmLevel := 0.
REQ-018 Escalation in ALARM (macro-dependent, REQ-022): sample > alarmLevel sets alarmLevel := sample on that edge; eventCount unchanged; lower or equal samples have no effect.
REQ-019 Escalation and ack sampled on the same edge: escalation applied, ack ignored, state remains ALARM.

Reset
REQ-020 reset=1 at a rising edge SHALL force state IDLE, alarm=0, alarmLevel=0, eventCount=0, all internal counters 0, from any state including mid-QUALIFY and mid-HOLDOFF.
REQ-021 reset SHALL take priority over every other input on the same edge.

Configuration
REQ-022 Macro NERVOUS_ALARM_ESCALATION_EN defined: REQ-018 active; undefined: alarmLevel frozen from alarm entry until REQ-017 clears it, and the escalation logic is not compiled.

Structure
REQ-023 Package nervous_alarm_pkg SHALL hold the FSM state type and the severity code constants (NORMAL, MILD, SEVERE, CRITICAL).
REQ-024 The candidate/persistence counting SHALL be a sub-module abnormality_persistence_filter (outputs qualified pulse and candidate code); the FSM, holdoff counter and event counter stay in the top.

Verification (PERSIST_CYCLES=4, HOLDOFF_CYCLES=8 unless stated)
REQ-025 After reset, code 1 held 4 edges -> alarm=1, alarmLevel=1, eventCount=1 after 4th edge.
REQ-026 Code 2 for 3 edges, then 0 -> alarm stays 0, eventCount 0; code 1,1,2,2,2,2 -> alarm after 6th edge with alarmLevel=2.
REQ-027 In ALARM at level 1, code 3 for one edge -> alarmLevel=3 next edge with macro; stays 1 without; ack on that same edge is ignored with macro.
REQ-028 ack pulse in ALARM, code 2 held continuously -> alarm=0 next edge, alarm stays 0 through 8 holdoff edges, re-asserts 4 edges after holdoff ends, eventCount=2.
REQ-029 reset asserted in ALARM and in HOLDOFF -> all outputs 0 on that edge; next qualification needs full 4 edges.
REQ-030 CNT_WIDTH=2, 5 qualified alarms with acks -> eventCount reads 1,2,3,3,3.
